scrub_mon_poller: RTL and testbench
===================================

Name: scrub_mon_poller

Overview:
- REG_BUS initiator that periodically reads the two read-only registers of the bit-flip scrub monitor and republishes them as plain signals for the interrupt controller/host glue.
- Registers read: word 0 = interrupt flag (bit 0), word 1 = average cycles per bit flip.
- Handles the ready/error response, adds a transaction timeout, and derives an alarm from the interrupt flag and a cycles-per-flip threshold.

Parameters:
- ADDR_WIDTH, 32, REG_BUS address width.
- DATA_WIDTH, 32, REG_BUS data width; width of the cycles-per-flip value.
- BASE_ADDR, 0, address of monitor word 0; word 1 is at BASE_ADDR+1.
- POLL_PERIOD, 1000, clock cycles from the end of one poll to the start of the next (≥2).
- TIMEOUT, 16, cycles waiting for ready/error before the transaction is abandoned (≥2).
- CYCLE_THR, 100, alarm when a nonzero cycles-per-flip value is below this.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- enable_i  in  1  periodic polling enabled
- poll_now_i  in  1  pulse: start a poll immediately if IDLE
- reg_addr_o  out  ADDR_WIDTH  REG_BUS addr
- reg_write_o  out  1  REG_BUS write, constant 0
- reg_wdata_o  out  DATA_WIDTH  constant 0
- reg_wstrb_o  out  DATA_WIDTH/8  constant 0
- reg_valid_o  out  1  REG_BUS valid
- reg_rdata_i  in  DATA_WIDTH  REG_BUS rdata
- reg_ready_i  in  1  REG_BUS ready
- reg_error_i  in  1  REG_BUS error
- interr_o  out  1  last read interrupt flag
- cyclesxbf_o  out  DATA_WIDTH  last read cycles-per-flip
- sample_valid_o  out  1  1-cycle pulse: both words read successfully
- alarm_o  out  1  interr_o OR (cyclesxbf_o != 0 AND cyclesxbf_o < CYCLE_THR)
- bus_err_o  out  1  sticky: error or timeout seen; cleared by reset or next successful poll

Behaviour:
- Reset (synchronous, rst_i high at posedge): state IDLE, all outputs 0, interval timer loaded with POLL_PERIOD, timeout timer idle. Reset mid-transaction drops reg_valid_o on the next edge, with no completion.
- Every output is registered. reg_addr_o is stable whenever reg_valid_o=1.
- FSM IDLE -> RD_INT -> RD_CNT -> UPD -> IDLE:
  - IDLE: interval timer counts down only while enable_i=1. Leave IDLE at expiry or on poll_now_i. poll_now_i works even with enable_i=0. If both fire in the same cycle, only one poll starts.
  - RD_INT: reg_valid_o=1, reg_addr_o=BASE_ADDR. The transaction completes in the first cycle with reg_valid_o=1 and (reg_ready_i or reg_error_i); reg_valid_o drops on the next edge.
    - ready: latch reg_rdata_i[0] into a shadow, then go to RD_CNT.
    - error, or TIMEOUT cycles with no response: set bus_err_o, skip to IDLE, outputs unchanged.
    - ready and error together: treat as error.
  - RD_CNT: same rules at BASE_ADDR+1. On ready, shadow the data and go to UPD.
  - UPD (1 cycle): copy both shadows to interr_o/cyclesxbf_o, pulse sample_valid_o, clear bus_err_o, reload the interval timer, go to IDLE.
- Handshake detail: the responder registers ready one cycle after valid and can pulse ready again in the cycle after completion. ready/error are sampled only in RD_INT/RD_CNT with reg_valid_o=1; the cycle after completion carries reg_valid_o=0 (one idle gap between the two reads), so that stray pulse is ignored.
- Nominal latency with a 1-cycle responder, poll start to sample_valid_o: RD_INT 2 + RD_CNT 2 + UPD 1 = 5 cycles.
- alarm_o is recomputed from the registered outputs (1 cycle after UPD). The comparison is an unsigned DATA_WIDTH compare.
- Interval timer wraps by reload, never by overflow. poll_now_i outside IDLE is ignored.
- enable_i deasserted mid-poll: the poll completes and the next period is not counted.

Optional Feature:
- Macro POLL_RETRY_EN.
- Defined: an error or timeout in RD_INT/RD_CNT reissues the same read once, after a 1-cycle gap. Only a second failure sets bus_err_o and aborts.
- Undefined: the first failure aborts as described above.

Decomposition:
- Package scrub_poll_pkg:
  - state_t enum (IDLE, RD_INT, RD_CNT, UPD, plus RETRY when enabled);
  - word offsets OFS_INTERR=0, OFS_CYCLESXBF=1;
  - INTERR_BIT=0.
- Sub-module scrub_poll_timer: loadable down-counter with enable and expire flag, instantiated twice (interval, timeout).

Test Plan:
- Reset, enable_i=1, responder returns word0=1, word1=250 -> sample_valid_o pulses 5 cycles after first valid; interr_o=1, cyclesxbf_o=250, alarm_o=1. Second poll starts 1000 cycles after UPD.
- word0=0, word1=40, CYCLE_THR=100 -> alarm_o=1. word1=0 -> alarm_o=0. word1=100 -> alarm_o=0.
- Responder asserts reg_error_i on word1 -> bus_err_o=1, cyclesxbf_o keeps its old value, no sample_valid_o. Next good poll clears bus_err_o.
- Responder silent -> reg_valid_o held exactly 16 cycles, then dropped, bus_err_o=1. With POLL_RETRY_EN: two 16-cycle attempts before bus_err_o=1.
- Responder pulses ready in 2 consecutive cycles -> only one completion is counted, and the RD_CNT address (BASE_ADDR+1) is issued once.
- rst_i asserted while in RD_CNT -> next cycle reg_valid_o=0, all outputs 0. poll_now_i with enable_i=0 -> exactly one poll.

Source files
------------

// File: rtl/scrub_mon_poller_pkg.sv
// ---------------------------------------------------------------------------
// scrub_poll_pkg
// Shared types and constants for the scrub monitor poller.
//   state_t        : poller FSM states (RETRY exists only when POLL_RETRY_EN
//                    is defined)
//   OFS_INTERR     : word offset of the monitor interrupt flag register
//   OFS_CYCLESXBF  : word offset of the cycles-per-bit-flip register
//   INTERR_BIT     : bit position of the interrupt flag inside word 0
// Configuration macro: POLL_RETRY_EN
// ---------------------------------------------------------------------------
package scrub_poll_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_INT = 3'd1,
        RD_CNT = 3'd2,
`ifdef POLL_RETRY_EN
        RETRY  = 3'd4,
`endif
        UPD    = 3'd3
    } state_t;

    localparam int OFS_INTERR    = 0;
    localparam int OFS_CYCLESXBF = 1;
    localparam int INTERR_BIT    = 0;

endpackage

// File: rtl/scrub_mon_poller_timer.sv
// ---------------------------------------------------------------------------
// scrub_poll_timer
// Loadable down-counter. Load has priority over decrement; the counter never
// wraps (it holds at zero). expired_o flags the last counted cycle (count 1)
// so the owner can act on the edge that ends it.
//   clk_i       : clock
//   rst_i       : synchronous active-high reset, loads RST_VAL
//   load_i      : load load_val_i on the next edge
//   load_val_i  : reload value
//   dec_i       : decrement enable
//   expired_o   : count has reached 1 (or 0)
// ---------------------------------------------------------------------------
module scrub_poll_timer #(
    parameter int             W       = 32,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= RST_VAL;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired_o = (cnt_q < W'(2));

endmodule

// File: rtl/scrub_mon_poller.sv
// ---------------------------------------------------------------------------
// scrub_mon_poller
// REG_BUS initiator that periodically reads the scrub monitor's interrupt
// flag (word 0) and average cycles-per-bit-flip (word 1) and republishes them
// as registered signals, with an alarm and a sticky bus error flag.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   enable_i            : periodic polling enabled
//   poll_now_i          : start a poll immediately when idle
//   reg_*_o / reg_*_i   : REG_BUS read-only initiator port
//   interr_o            : last interrupt flag read
//   cyclesxbf_o         : last cycles-per-flip value read
//   sample_valid_o      : 1-cycle pulse when both words were read
//   alarm_o             : interr_o | (0 < cyclesxbf_o < CYCLE_THR)
//   bus_err_o           : sticky error/timeout flag, cleared by a good poll
//   dbg_state_o         : current FSM state
// Configuration macro: POLL_RETRY_EN (reissue a failed read once).
//
// Handshake: a read is offered while reg_valid_o=1 with reg_addr_o held
// stable; it completes in the first cycle where reg_valid_o=1 and
// reg_ready_i or reg_error_i is high (error wins when both are high).
// reg_valid_o drops on the following edge, so the responder's extra ready
// pulse lands in a reg_valid_o=0 cycle and is ignored.
// ---------------------------------------------------------------------------
module scrub_mon_poller
    import scrub_poll_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BASE_ADDR   = 0,
    parameter int POLL_PERIOD = 1000,
    parameter int TIMEOUT     = 16,
    parameter int CYCLE_THR   = 100
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    poll_now_i,
    output logic [ADDR_WIDTH-1:0]   reg_addr_o,
    output logic                    reg_write_o,
    output logic [DATA_WIDTH-1:0]   reg_wdata_o,
    output logic [DATA_WIDTH/8-1:0] reg_wstrb_o,
    output logic                    reg_valid_o,
    input  logic [DATA_WIDTH-1:0]   reg_rdata_i,
    input  logic                    reg_ready_i,
    input  logic                    reg_error_i,
    output logic                    interr_o,
    output logic [DATA_WIDTH-1:0]   cyclesxbf_o,
    output logic                    sample_valid_o,
    output logic                    alarm_o,
    output logic                    bus_err_o,
    output state_t                  dbg_state_o
);

    localparam int TMR_W = 32;
    localparam logic [ADDR_WIDTH-1:0] ADDR_INT = ADDR_WIDTH'(BASE_ADDR + OFS_INTERR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CNT = ADDR_WIDTH'(BASE_ADDR + OFS_CYCLESXBF);
    localparam logic [DATA_WIDTH-1:0] THR      = DATA_WIDTH'(CYCLE_THR);
    localparam logic [TMR_W-1:0]      PERIOD_V = TMR_W'(POLL_PERIOD);
    localparam logic [TMR_W-1:0]      TMO_V    = TMR_W'(TIMEOUT);

    state_t state_q;
    logic   interr_shadow_q;
    logic   iv_expired;
    logic   to_expired;
    logic   poll_start;
    logic   rsp_ok;
    logic   rsp_fail;
`ifdef POLL_RETRY_EN
    logic   retried_q;
    state_t retry_state_q;
`endif

    assign reg_write_o = 1'b0;
    assign reg_wdata_o = '0;
    assign reg_wstrb_o = '0;
    assign dbg_state_o = state_q;

    // Timer expiry and poll_now_i in the same cycle still start a single poll.
    assign poll_start = (state_q == IDLE) && (poll_now_i || (enable_i && iv_expired));
    assign rsp_ok     = reg_valid_o && reg_ready_i && !reg_error_i;
    assign rsp_fail   = reg_valid_o && (reg_error_i || (!reg_ready_i && to_expired));

    // Interval timer: held at the period for the whole poll, so the idle
    // countdown always starts from a fresh reload.
    scrub_poll_timer #(.W(TMR_W), .RST_VAL(PERIOD_V)) u_interval (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (state_q != IDLE),
        .load_val_i (PERIOD_V),
        .dec_i      ((state_q == IDLE) && enable_i),
        .expired_o  (iv_expired)
    );

    // Timeout timer: reloaded whenever no read is outstanding, so it holds
    // TIMEOUT in the first valid cycle and expires on the TIMEOUT-th.
    scrub_poll_timer #(.W(TMR_W), .RST_VAL(TMO_V)) u_timeout (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (!reg_valid_o),
        .load_val_i (TMO_V),
        .dec_i      (reg_valid_o),
        .expired_o  (to_expired)
    );

    // Outputs are registered from the state being entered: the edge that
    // finishes word 1 also publishes the sample, so those values are visible
    // during the single UPD cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            reg_valid_o     <= 1'b0;
            reg_addr_o      <= '0;
            interr_shadow_q <= 1'b0;
            interr_o        <= 1'b0;
            cyclesxbf_o     <= '0;
            sample_valid_o  <= 1'b0;
            alarm_o         <= 1'b0;
            bus_err_o       <= 1'b0;
`ifdef POLL_RETRY_EN
            retried_q       <= 1'b0;
            retry_state_q   <= IDLE;
`endif
        end else begin
            sample_valid_o <= 1'b0;
            alarm_o        <= interr_o || ((cyclesxbf_o != '0) && (cyclesxbf_o < THR));
            case (state_q)
                IDLE: begin
                    if (poll_start) begin
                        state_q     <= RD_INT;
                        reg_valid_o <= 1'b1;
                        reg_addr_o  <= ADDR_INT;
                    end
                end
                RD_INT, RD_CNT: begin
                    if (!reg_valid_o) begin
                        // Gap cycle after the previous read: issue this one.
                        reg_valid_o <= 1'b1;
                        reg_addr_o  <= (state_q == RD_INT) ? ADDR_INT : ADDR_CNT;
                    end else if (rsp_ok) begin
                        reg_valid_o <= 1'b0;
`ifdef POLL_RETRY_EN
                        retried_q   <= 1'b0;
`endif
                        if (state_q == RD_INT) begin
                            interr_shadow_q <= reg_rdata_i[INTERR_BIT];
                            state_q         <= RD_CNT;
                        end else begin
                            interr_o       <= interr_shadow_q;
                            cyclesxbf_o    <= reg_rdata_i;
                            sample_valid_o <= 1'b1;
                            bus_err_o      <= 1'b0;
                            state_q        <= UPD;
                        end
                    end else if (rsp_fail) begin
                        reg_valid_o <= 1'b0;
`ifdef POLL_RETRY_EN
                        if (!retried_q) begin
                            retried_q     <= 1'b1;
                            retry_state_q <= state_q;
                            state_q       <= RETRY;
                        end else begin
                            retried_q <= 1'b0;
                            bus_err_o <= 1'b1;
                            state_q   <= IDLE;
                        end
`else
                        bus_err_o <= 1'b1;
                        state_q   <= IDLE;
`endif
                    end
                end
`ifdef POLL_RETRY_EN
                RETRY: begin
                    // One idle cycle has passed; reissue the same address.
                    state_q     <= retry_state_q;
                    reg_valid_o <= 1'b1;
                end
`endif
                UPD: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scrub_mon_poller.sv
// ---------------------------------------------------------------------------
// tb_scrub_mon_poller
// Self-checking bench for scrub_mon_poller with a configurable REG_BUS
// responder, a poll-level reference model and a sample scoreboard.
// Honours POLL_RETRY_EN when defined for the whole build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_scrub_mon_poller;
    import scrub_poll_pkg::*;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int BASE   = 'h40;
    localparam int PERIOD = 1000;
    localparam int TMO    = 16;
    localparam int THR    = 100;
`ifdef POLL_RETRY_EN
    localparam int ATT = 2;
`else
    localparam int ATT = 1;
`endif
    // responder behaviour per word
    localparam int M_OK = 0, M_ERR = 1, M_SIL = 2, M_DBL = 3, M_BOTH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b0;
    logic            poll_now = 1'b0;
    logic [AW-1:0]   reg_addr;
    logic            reg_write;
    logic [DW-1:0]   reg_wdata;
    logic [DW/8-1:0] reg_wstrb;
    logic            reg_valid;
    logic [DW-1:0]   reg_rdata = '0;
    logic            reg_ready = 1'b0;
    logic            reg_error = 1'b0;
    logic            interr;
    logic [DW-1:0]   cyclesxbf;
    logic            sample_valid;
    logic            alarm;
    logic            bus_err;
    state_t          dbg_state;

    scrub_mon_poller #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE),
        .POLL_PERIOD(PERIOD), .TIMEOUT(TMO), .CYCLE_THR(THR)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .poll_now_i(poll_now),
        .reg_addr_o(reg_addr), .reg_write_o(reg_write), .reg_wdata_o(reg_wdata),
        .reg_wstrb_o(reg_wstrb), .reg_valid_o(reg_valid), .reg_rdata_i(reg_rdata),
        .reg_ready_i(reg_ready), .reg_error_i(reg_error), .interr_o(interr),
        .cyclesxbf_o(cyclesxbf), .sample_valid_o(sample_valid), .alarm_o(alarm),
        .bus_err_o(bus_err), .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // ---------------- responder: registered, 1-cycle latency ----------------
    int            mode [2] = '{M_OK, M_OK};
    logic [DW-1:0] data [2] = '{'0, '0};
    logic          extra = 1'b0;
    int            rw;

    always @(posedge clk) begin
        reg_ready <= 1'b0;
        reg_error <= 1'b0;
        if (rst) begin
            extra <= 1'b0;
        end else if (extra) begin
            reg_ready <= 1'b1;
            extra     <= 1'b0;
        end else if (reg_valid && !reg_ready && !reg_error) begin
            rw = (reg_addr == AW'(BASE + 1)) ? 1 : 0;
            case (mode[rw])
                M_OK:   begin reg_ready <= 1'b1; reg_rdata <= data[rw]; end
                M_DBL:  begin reg_ready <= 1'b1; reg_rdata <= data[rw]; extra <= 1'b1; end
                M_ERR:  begin reg_error <= 1'b1; reg_rdata <= $urandom; end
                M_BOTH: begin reg_ready <= 1'b1; reg_error <= 1'b1; reg_rdata <= $urandom; end
                default: ;
            endcase
        end
    end

    // ---------------- monitor + scoreboard ----------------
    logic [DW:0] exp_q[$];
    int cyc_n = 0;
    int valid_cycles, addr0_issues, addr1_issues, sample_cnt;
    int first_valid_cyc, sample_cyc, addr0_cyc;
    bit seen_rise;
    logic prev_valid = 1'b0;

    task automatic clear_mon();
        valid_cycles = 0; addr0_issues = 0; addr1_issues = 0; sample_cnt = 0;
        first_valid_cyc = 0; sample_cyc = 0; addr0_cyc = 0; seen_rise = 0;
    endtask

    always @(negedge clk) begin
        cyc_n++;
        if (reg_valid) valid_cycles++;
        if (reg_valid && !prev_valid) begin
            if (!seen_rise) begin
                seen_rise = 1;
                first_valid_cyc = cyc_n;
            end
            if (reg_addr == AW'(BASE)) begin
                addr0_issues++;
                addr0_cyc = cyc_n;
            end
            if (reg_addr == AW'(BASE + 1)) addr1_issues++;
        end
        if (sample_valid) begin
            sample_cnt++;
            sample_cyc = cyc_n;
            if (exp_q.size() == 0) check_eq("sb_unexpected_sample", 64'(sample_valid), 64'd0);
            else check_eq("sb_sample", 64'({interr, cyclesxbf}), 64'(exp_q.pop_front()));
        end
        prev_valid = reg_valid;
    end

    // ---------------- reference model ----------------
    logic          exp_interr = 1'b0;
    logic [DW-1:0] exp_cyc = '0;
    logic          exp_berr = 1'b0;

    function automatic bit is_ok(input int m);
        return (m == M_OK) || (m == M_DBL);
    endfunction

    // valid-high cycles one word read costs, retries included
    function automatic int cost(input int m);
        if (is_ok(m)) return 2;
        if (m == M_SIL) return TMO * ATT;
        return 2 * ATT;
    endfunction

    function automatic logic exp_alarm();
        return exp_interr || ((exp_cyc != 0) && (exp_cyc < DW'(THR)));
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, "_interr"}, 64'(interr), 64'(exp_interr));
        check_eq({tag, "_cyclesxbf"}, 64'(cyclesxbf), 64'(exp_cyc));
        check_eq({tag, "_alarm"}, 64'(alarm), 64'(exp_alarm()));
        check_eq({tag, "_bus_err"}, 64'(bus_err), 64'(exp_berr));
    endtask

    // One poll started by poll_now with enable low; model predicts outcome.
    task automatic do_poll(input string tag, input int m0, input int m1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        bit good;
        int exp_valid, exp_a0, exp_a1;
        good      = is_ok(m0) && is_ok(m1);
        exp_valid = cost(m0) + (is_ok(m0) ? cost(m1) : 0);
        exp_a0    = is_ok(m0) ? 1 : ATT;
        exp_a1    = is_ok(m0) ? (is_ok(m1) ? 1 : ATT) : 0;
        if (good) begin
            exp_interr = d0[0];
            exp_cyc    = d1;
            exp_berr   = 1'b0;
            exp_q.push_back({d0[0], d1});
        end else begin
            exp_berr = 1'b1;
        end
        mode[0] = m0; mode[1] = m1; data[0] = d0; data[1] = d1;
        clear_mon();
        @(posedge clk); #1 poll_now = 1'b1;
        @(posedge clk); #1 poll_now = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check_outputs(tag);
        check_eq({tag, "_samples"}, 64'(sample_cnt), 64'(good ? 1 : 0));
        check_eq({tag, "_valid_cycles"}, 64'(valid_cycles), 64'(exp_valid));
        check_eq({tag, "_addr0_issues"}, 64'(addr0_issues), 64'(exp_a0));
        check_eq({tag, "_addr1_issues"}, 64'(addr1_issues), 64'(exp_a1));
        if (good) check_eq({tag, "_latency"}, 64'(sample_cyc - first_valid_cyc), 64'd5);
    endtask

    // ---------------- main sequence ----------------
    int s1;
    logic [DW-1:0] rd0, rd1;
    int rm0, rm1;

    initial begin
        clear_mon();
        do_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", 64'(reg_valid), 64'd0);
        check_eq("rst_addr", 64'(reg_addr), 64'd0);
        check_eq("rst_write", 64'(reg_write), 64'd0);
        check_eq("rst_wdata", 64'(reg_wdata), 64'd0);
        check_eq("rst_wstrb", 64'(reg_wstrb), 64'd0);
        check_eq("rst_sample", 64'(sample_valid), 64'd0);
        check_outputs("rst");

        // periodic polling: first poll, then the gap to the second one
        mode[0] = M_OK; mode[1] = M_OK; data[0] = 1; data[1] = 250;
        exp_q.push_back({1'b1, DW'(250)});
        clear_mon();
        enable = 1'b1;
        for (int i = 0; i < 1100 && sample_cnt < 1; i++) @(posedge clk);
        check_eq("per1_sample_seen", 64'(sample_cnt), 64'd1);
        check_eq("per1_latency", 64'(sample_cyc - first_valid_cyc), 64'd5);
        repeat (2) @(posedge clk);
        #1;
        exp_interr = 1'b1; exp_cyc = 250; exp_berr = 1'b0;
        check_outputs("per1");
        data[0] = 0; data[1] = 40;
        exp_q.push_back({1'b0, DW'(40)});
        s1 = sample_cyc;
        for (int i = 0; i < 1100 && addr0_issues < 2; i++) @(posedge clk);
        // UPD is the sample cycle; POLL_PERIOD idle cycles follow it
        check_eq("per2_gap", 64'(addr0_cyc - s1), 64'(PERIOD + 1));
        for (int i = 0; i < 20 && sample_cnt < 2; i++) @(posedge clk);
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_interr = 1'b0; exp_cyc = 40;
        check_eq("per2_sample_seen", 64'(sample_cnt), 64'd2);
        check_outputs("per2");

        // directed patterns
        do_poll("thr_40",    M_OK,  M_OK,   0, 40);
        do_poll("thr_0",     M_OK,  M_OK,   0, 0);
        do_poll("thr_100",   M_OK,  M_OK,   0, 100);
        do_poll("thr_99",    M_OK,  M_OK,   2, 99);
        do_poll("err_w1",    M_OK,  M_ERR,  1, 77);
        do_poll("recover",   M_OK,  M_OK,   0, 300);
        do_poll("sil_w0",    M_SIL, M_OK,   1, 5);
        do_poll("sil_w1",    M_OK,  M_SIL,  1, 5);
        do_poll("dbl",       M_DBL, M_DBL,  1, 500);
        do_poll("both_w0",   M_BOTH, M_OK,  0, 7);
        do_poll("err_w0",    M_ERR, M_OK,   0, 8);
        do_poll("recover2",  M_OK,  M_DBL,  3, 1);

        // randomized polls
        for (int n = 0; n < 12; n++) begin
            rm0 = $urandom_range(0, 9);
            rm1 = $urandom_range(0, 9);
            rm0 = (rm0 < 5) ? M_OK : (rm0 < 7) ? M_DBL : (rm0 == 7) ? M_ERR : (rm0 == 8) ? M_BOTH : M_SIL;
            rm1 = (rm1 < 5) ? M_OK : (rm1 < 7) ? M_DBL : (rm1 == 7) ? M_ERR : (rm1 == 8) ? M_BOTH : M_SIL;
            rd0 = $urandom;
            case ($urandom_range(0, 5))
                0: rd1 = 0;
                1: rd1 = THR - 1;
                2: rd1 = THR;
                3: rd1 = THR + 1;
                4: rd1 = $urandom_range(1, THR);
                default: rd1 = $urandom;
            endcase
            do_poll("rand", rm0, rm1, rd0, rd1);
        end

        // reset while word 1 is outstanding
        do_poll("pre_rst", M_OK, M_OK, 1, 9);
        mode[0] = M_OK; mode[1] = M_SIL; data[0] = 1; data[1] = 123;
        clear_mon();
        @(posedge clk); #1 poll_now = 1'b1;
        @(posedge clk); #1 poll_now = 1'b0;
        for (int i = 0; i < 30 && !(reg_valid && reg_addr == AW'(BASE + 1)); i++) begin
            @(posedge clk); #1;
        end
        check_eq("mid_rdcnt_reached", 64'(reg_valid && reg_addr == AW'(BASE + 1)), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        exp_interr = 1'b0; exp_cyc = '0; exp_berr = 1'b0;
        check_eq("mid_rst_valid", 64'(reg_valid), 64'd0);
        check_eq("mid_rst_addr", 64'(reg_addr), 64'd0);
        check_eq("mid_rst_sample", 64'(sample_valid), 64'd0);
        check_outputs("mid_rst");
        rst = 1'b0;
        do_poll("post_rst", M_OK, M_OK, 1, 60);

        check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
